odeme_hakem: RTL
================

Name: odeme_hakem

Overview:
- Round-robin arbiter and sequencer that shares one `odeme` payment unit between N_IST requesters (e.g. several card readers).
- Per transaction it latches the winning requester's fee and balance, drives the `odeme` start, and waits for done with a timeout.
- It returns the result tagged with the requester id, then pulses the `odeme` reset so the unit is clean for the next transaction.

Parameters:
- N_IST, 4, number of requesters; legal range 2..8.
- ZAMAN_ASIMI, 15, maximum cycles spent in BEKLE before the transaction is aborted; legal range 1..255.
- Localparam ID_W = $clog2(N_IST).

Ports:
- saat  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- istek  in  N_IST  per-requester request level; held until kabul.
- ucret_in  in  8*N_IST  fee of requester i at bits [8i+7:8i].
- bakiye_in  in  9*N_IST  balance of requester i at bits [9i+8:9i].
- kabul  out  N_IST  one-hot, 1-cycle grant pulse.
- sonuc_gecerli  out  1  1-cycle result-valid pulse.
- sonuc_id  out  ID_W  id of the requester whose result is presented.
- sonuc_onay  out  1  payment approved.
- sonuc_k_bakiye  out  9  remaining balance.
- sonuc_zaman_asimi  out  1  transaction aborted by timeout.
- o_basla  out  1  start to `odeme`.
- o_ucret  out  8  fee to `odeme`.
- o_bakiye  out  9  balance to `odeme`.
- o_reset  out  1  reset to `odeme`.
- o_onay  in  1  approval from `odeme`.
- o_k_bakiye  in  9  remaining balance from `odeme`.
- o_bitti  in  1  done from `odeme`.
- hata  out  1  sticky consistency error (see Optional Feature).

Behaviour:
- Reset values:
  - kabul, sonuc_*, o_basla, o_ucret, o_bakiye and hata are all 0.
  - State = BOS, round-robin pointer son_id = N_IST-1, timeout counter = 0.
  - o_reset = 1 while reset is high (o_reset = reset OR state==TEMIZLE).
- States: BOS, BASLAT, BEKLE, SONUC, TEMIZLE.
- BOS:
  - istek is sampled only in BOS.
  - If any bit is set, the winner is the first set bit searching from son_id+1 upward, wrapping at N_IST-1 to 0.
  - On the winning edge:
    - Register the winner's ucret/bakiye into o_ucret/o_bakiye.
    - Register the winner id and update son_id to the winner.
    - Pulse kabul[id] for the next cycle.
    - Go to BASLAT.
  - With no request, stay in BOS with all outputs idle.
- BASLAT: o_basla=1, counter cleared; go to BEKLE.
- BEKLE:
  - o_basla stays 1 and o_ucret/o_bakiye are held stable.
  - If o_bitti=1: capture o_onay and o_k_bakiye, set zaman_asimi=0, go to SONUC.
  - Else, if the counter reaches ZAMAN_ASIMI-1: set onay=0, k_bakiye = latched bakiye, zaman_asimi=1, go to SONUC.
  - Otherwise increment the counter.
  - o_bitti takes priority over timeout in the same cycle.
- SONUC:
  - o_basla=0.
  - sonuc_gecerli=1 for exactly this cycle; sonuc_id, sonuc_onay, sonuc_k_bakiye and sonuc_zaman_asimi are valid.
  - The sonuc_* data fields hold their values until the next SONUC.
  - Go to TEMIZLE.
- TEMIZLE: o_reset=1 for one cycle; go to BOS.
- Minimum spacing between grants is 5 cycles (BOS→BASLAT→BEKLE→SONUC→TEMIZLE→BOS).
- Requester obligation: drop istek in the cycle after kabul. A request still high when the arbiter returns to BOS counts as a new request.
- No arithmetic is done in the arbiter; widths are passed through unchanged.
- Reset mid-transaction:
  - Abort immediately; no sonuc_gecerli is produced.
  - The `odeme` unit is reset.
  - son_id returns to N_IST-1, so requester 0 has priority next.
- Only one kabul bit is ever set. kabul and sonuc_gecerli are never high in the same cycle.

Optional Feature:
- Macro: ODEME_DENETIM_EN.
- When defined, the check is done in BEKLE on o_bitti=1 against the latched operands. hata sets and stays set until reset if either:
  - o_onay=1 and o_k_bakiye ≠ o_bakiye − o_ucret, or
  - o_onay=0 and (o_k_bakiye ≠ o_bakiye or o_ucret ≤ o_bakiye).
- Result forwarding is unaffected by the check.
- When not defined, hata is tied to 0 and no checking logic is generated.

Test Plan:
- Single request, real `odeme`: istek=0001, ucret0=14, bakiye0=45 → kabul=0001 one cycle later; sonuc_gecerli with sonuc_id=0, onay=1, k_bakiye=31, zaman_asimi=0; then a 1-cycle o_reset pulse.
- All requesters at once after reset, istek=1111: ucret=14,77,69,22 and bakiye=45,87,11,99 → served in order 0,1,2,3. Results:
  - 1/31
  - 1/10
  - 0/11
  - 1/77
- Rotation fairness: requester 1 just served, then istek=0011 → next grant to 0, and requester 1 is not granted twice in a row.
- Timeout: o_bitti stubbed to 0, req 2 with ucret=56, bakiye=13 → sonuc_gecerli 15 cycles after entering BEKLE, with sonuc_id=2, onay=0, k_bakiye=13, zaman_asimi=1.
- Reset in BEKLE → next cycle all outputs 0, o_reset=1, no sonuc_gecerli. After release, istek=1001 → requester 0 granted first.
- With ODEME_DENETIM_EN: stub returns onay=1, k_bakiye=30 for ucret=14, bakiye=45 → hata=1 and stays 1 until reset. Without the macro → hata stays 0.

Source files
------------

// File: rtl/odeme_hakem.sv
// ============================================================================
// odeme_hakem : round-robin arbiter/sequencer sharing one odeme payment unit.
// Optional build macro: ODEME_DENETIM_EN (result consistency checker -> hata).
// Rev 1.0
// ============================================================================
`default_nettype none

module odeme_hakem #(
  parameter int N_IST       = 4,
  parameter int ZAMAN_ASIMI = 15
) (
  input  logic                       saat,
  input  logic                       reset,
  input  logic [N_IST-1:0]           istek,
  input  logic [8*N_IST-1:0]         ucret_in,
  input  logic [9*N_IST-1:0]         bakiye_in,
  output logic [N_IST-1:0]           kabul,
  output logic                       sonuc_gecerli,
  output logic [$clog2(N_IST)-1:0]   sonuc_id,
  output logic                       sonuc_onay,
  output logic [8:0]                 sonuc_k_bakiye,
  output logic                       sonuc_zaman_asimi,
  output logic                       o_basla,
  output logic [7:0]                 o_ucret,
  output logic [8:0]                 o_bakiye,
  output logic                       o_reset,
  input  logic                       o_onay,
  input  logic [8:0]                 o_k_bakiye,
  input  logic                       o_bitti,
  output logic                       hata
);

  localparam int ID_W = $clog2(N_IST);

  typedef enum logic [2:0] {
    BOS     = 3'd0,
    BASLAT  = 3'd1,
    BEKLE   = 3'd2,
    SONUC   = 3'd3,
    TEMIZLE = 3'd4
  } durum_t;

  durum_t          r_durum;
  logic [ID_W-1:0] r_son_id;
  logic [ID_W-1:0] r_id;
  logic [7:0]      r_sayac;

  logic            w_var;
  logic [ID_W-1:0] w_kazanan;
  logic [7:0]      w_ucret;
  logic [8:0]      w_bakiye;

  // Scan from farthest to nearest so the first set bit after son_id wins.
  always_comb begin
    w_var     = 1'b0;
    w_kazanan = '0;
    w_ucret   = '0;
    w_bakiye  = '0;
    for (int k = N_IST; k >= 1; k--) begin
      automatic int j = int'(r_son_id) + k;
      if (j >= N_IST) j = j - N_IST;
      if (istek[j]) begin
        w_var     = 1'b1;
        w_kazanan = ID_W'(j);
        w_ucret   = ucret_in[8*j +: 8];
        w_bakiye  = bakiye_in[9*j +: 9];
      end
    end
  end

  assign o_reset = reset | (r_durum == TEMIZLE);

  always_ff @(posedge saat) begin
    if (reset) begin
      r_durum           <= BOS;
      r_son_id          <= ID_W'(N_IST - 1);
      r_id              <= '0;
      r_sayac           <= '0;
      kabul             <= '0;
      sonuc_gecerli     <= 1'b0;
      sonuc_id          <= '0;
      sonuc_onay        <= 1'b0;
      sonuc_k_bakiye    <= '0;
      sonuc_zaman_asimi <= 1'b0;
      o_basla           <= 1'b0;
      o_ucret           <= '0;
      o_bakiye          <= '0;
    end else begin
      kabul         <= '0;
      sonuc_gecerli <= 1'b0;
      case (r_durum)
        BOS: begin
          if (w_var) begin
            o_ucret  <= w_ucret;
            o_bakiye <= w_bakiye;
            r_id     <= w_kazanan;
            r_son_id <= w_kazanan;
            kabul    <= N_IST'(1) << w_kazanan;
            o_basla  <= 1'b1;
            r_durum  <= BASLAT;
          end
        end
        BASLAT: begin
          r_sayac <= '0;
          r_durum <= BEKLE;
        end
        BEKLE: begin
          if (o_bitti) begin
            o_basla           <= 1'b0;
            sonuc_gecerli     <= 1'b1;
            sonuc_id          <= r_id;
            sonuc_onay        <= o_onay;
            sonuc_k_bakiye    <= o_k_bakiye;
            sonuc_zaman_asimi <= 1'b0;
            r_durum           <= SONUC;
          end else if (r_sayac == 8'(ZAMAN_ASIMI - 1)) begin
            o_basla           <= 1'b0;
            sonuc_gecerli     <= 1'b1;
            sonuc_id          <= r_id;
            sonuc_onay        <= 1'b0;
            sonuc_k_bakiye    <= o_bakiye;
            sonuc_zaman_asimi <= 1'b1;
            r_durum           <= SONUC;
          end else begin
            r_sayac <= r_sayac + 8'd1;
          end
        end
        SONUC:   r_durum <= TEMIZLE;
        TEMIZLE: r_durum <= BOS;
        default: r_durum <= BOS;
      endcase
    end
  end

`ifdef ODEME_DENETIM_EN
  logic r_hata;
  logic w_tutarsiz;

  // A decline is only consistent if the balance is untouched and truly short.
  assign w_tutarsiz = o_onay ? (o_k_bakiye != (o_bakiye - {1'b0, o_ucret}))
                             : ((o_k_bakiye != o_bakiye) || ({1'b0, o_ucret} <= o_bakiye));

  always_ff @(posedge saat) begin
    if (reset) begin
      r_hata <= 1'b0;
    end else if ((r_durum == BEKLE) && o_bitti && w_tutarsiz) begin
      r_hata <= 1'b1;
    end
  end

  assign hata = r_hata;
`else
  assign hata = 1'b0;
`endif

endmodule

`default_nettype wire
